wb_burst_mem_slave: RTL and testbench

- Synthesizable Wishbone B3 memory responder: the target end of the random burst traffic produced by the team's Wishbone BFM master and transactor.
- Supports classic cycles plus constant and incrementing bursts (linear, wrap-4/8/16) with registered feedback, byte-lane writes, out-of-range error signalling and programmable first-beat latency.
- Sits behind an interconnect port or is driven directly by the BFM master in regression benches.

---
 rtl/wb_burst_mem_slave_if.sv | 31 +++
 rtl/wb_burst_mem_slave.sv | 192 +++++++++++++++++++
 tb/tb_wb_burst_mem_slave.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_mem_slave_if.sv
// Wishbone B3 bus bundle for wb_burst_mem_slave; signal names keep the
// original slave-side port names so existing benches map one-to-one.
interface wb_burst_mem_slave_if #(
    parameter int unsigned aw = 32,
    parameter int unsigned dw = 32
);
    logic [aw-1:0]   wb_adr_i;
    logic [dw-1:0]   wb_dat_i;
    logic [dw/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [2:0]      wb_cti_i;
    logic [1:0]      wb_bte_i;
    logic [dw-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic            wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 burst memory responder (classic, constant, linear/wrap bursts).
// Define WB_MEM_WAIT_EN to enable programmable first-beat wait states.
module wb_burst_mem_slave #(
    parameter int unsigned   aw       = 32,
    parameter int unsigned   dw       = 32,
    parameter int unsigned   DEPTH    = 256,
    parameter logic [aw-1:0] MEM_BASE = '0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [3:0]          wait_states_i,
    wb_burst_mem_slave_if.slave wb
);

    localparam int unsigned   SW      = dw / 8;
    localparam int unsigned   LB      = (SW > 1) ? $clog2(SW) : 0;
    localparam int unsigned   MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [aw-1:0] DEPTH_A = aw'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [dw-1:0] dat_q, dat_d;
    logic [aw-1:0] pred_q, pred_d;
    logic          we_q, we_d;
    logic [2:0]    cti_q, cti_d;
    logic [1:0]    bte_q, bte_d;
`ifdef WB_MEM_WAIT_EN
    logic [3:0]    wait_cnt_q, wait_cnt_d;
`else
    logic          unused_wait_states;
    always_comb unused_wait_states = ^wait_states_i;
`endif

    logic [dw-1:0] mem [DEPTH];

    logic [aw-1:0] adr_off, adr_idx, nxt_idx;
    logic          adr_oor, bus_act, burst_cont, wr_en;

    always_comb begin
        adr_off = wb.wb_adr_i - MEM_BASE;
        adr_idx = adr_off >> LB;
        adr_oor = (wb.wb_adr_i < MEM_BASE) || (adr_idx >= DEPTH_A);
        bus_act = wb.wb_cyc_i && wb.wb_stb_i;
    end

    // Next predicted word: constant bursts hold, wrap modes keep the upper bits.
    always_comb begin
        nxt_idx = pred_q;
        if (cti_q == 3'b010) begin
            case (bte_q)
                2'b01:   nxt_idx = {pred_q[aw-1:2], pred_q[1:0] + 2'd1};
                2'b10:   nxt_idx = {pred_q[aw-1:3], pred_q[2:0] + 3'd1};
                2'b11:   nxt_idx = {pred_q[aw-1:4], pred_q[3:0] + 4'd1};
                default: nxt_idx = pred_q + 1'b1;
            endcase
        end
        burst_cont = ((cti_q == 3'b001) || (cti_q == 3'b010)) &&
                     ((wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010));
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        pred_d  = pred_q;
        we_d    = we_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        wr_en   = 1'b0;
`ifdef WB_MEM_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus_act) begin
                    pred_d = adr_idx;
                    we_d   = wb.wb_we_i;
                    cti_d  = wb.wb_cti_i;
                    bte_d  = wb.wb_bte_i;
                    if (adr_oor) begin
                        state_d = ERR;
                        err_d   = 1'b1;
`ifdef WB_MEM_WAIT_EN
                    end else if (wait_states_i != '0) begin
                        state_d    = WAIT;
                        wait_cnt_d = wait_states_i;
`endif
                    end else begin
                        state_d = BEAT;
                        ack_d   = 1'b1;
                        dat_d   = mem[adr_idx[MW-1:0]];
                    end
                end
            end
`ifdef WB_MEM_WAIT_EN
            WAIT: begin
                if (!bus_act) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q <= 4'd1) begin
                    state_d    = BEAT;
                    wait_cnt_d = '0;
                    ack_d      = 1'b1;
                    dat_d      = mem[pred_q[MW-1:0]];
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
`endif
            BEAT: begin
                wr_en = bus_act && we_q && !adr_oor;
                if (bus_act && burst_cont) begin
                    pred_d = nxt_idx;
                    if (nxt_idx >= DEPTH_A) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        dat_d = mem[nxt_idx[MW-1:0]];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!wb.wb_cyc_i) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            pred_q  <= '0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            bte_q   <= '0;
`ifdef WB_MEM_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            pred_q  <= pred_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
`ifdef WB_MEM_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Write uses the live bus address so master-side corrections are honoured.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[adr_idx[MW-1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Registered terminations are qualified by the live strobe so none is
    // presented on a cycle the master has already abandoned.
    always_comb begin
        wb.wb_ack_o = ack_q && bus_act;
        wb.wb_err_o = err_q && bus_act;
        wb.wb_rty_o = 1'b0;
        wb.wb_dat_o = dat_q;
    end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed scoreboard bench for wb_burst_mem_slave (32-bit bus, 256 words).
module tb_wb_burst_mem_slave;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
`ifdef WB_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ws = 4'd0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [256];

    wb_burst_mem_slave_if #(.aw(32), .dw(32)) bus ();

    wb_burst_mem_slave #(
        .aw(32), .dw(32), .DEPTH(256), .MEM_BASE(32'h0)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .wait_states_i (ws),
        .wb            (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] first_lat(input logic [3:0] w);
        return WAIT_EN ? 32'd1 + 32'(w) : 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        bus.wb_cyc_i = cyc;
        bus.wb_stb_i = stb;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_cti_i = cti;
        bus.wb_bte_i = bte;
    endtask

    task automatic bus_idle(input int unsigned n);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for the first termination; lat counts cycles after the strobe cycle.
    task automatic wait_term(output logic [31:0] lat, output logic a, output logic e);
        lat = 0;
        a = 1'b0;
        e = 1'b0;
        @(negedge clk);
        for (int unsigned i = 0; i < 40; i++) begin
            a = bus.wb_ack_o;
            e = bus.wb_err_o;
            if (a || e) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed ack with empty scoreboard, expected none", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.wb_dat_o, e);
        end
    endtask

    task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic exp_err, input string tag);
        logic [31:0] lat;
        logic        a, e;
        int unsigned w;
        w = adr >> 2;
        drive(1'b1, 1'b1, we, adr, dat, sel, 3'b000, 2'b00);
        if (!we && !exp_err) exp_q.push_back(model[w]);
        wait_term(lat, a, e);
        chk({tag, "_lat"}, lat, first_lat(ws));
        chk({tag, "_term"}, {30'd0, a, e}, exp_err ? 32'd1 : 32'd2);
        if (!we && !exp_err) begin
            if (a) sb_pop({tag, "_data"});
            else void'(exp_q.pop_back());
        end
        if (we && !exp_err && a) begin
            for (int unsigned b = 0; b < 4; b++)
                if (sel[b]) model[w][8*b +: 8] = dat[8*b +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic we, input logic [31:0] adr0, input int unsigned n,
                         input logic [1:0] bte, input logic [2:0] ctype, input logic [31:0] wbase,
                         input logic [31:0] err_beat, input logic eob, input string tag);
        logic [31:0] lat;
        logic        a, e, errored;
        int unsigned w, mask;
        logic [31:0] d;
        mask = (bte == 2'b01) ? 3 : (bte == 2'b10) ? 7 : (bte == 2'b11) ? 15 : 32'hFFFF_FFFF;
        w = adr0 >> 2;
        errored = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            d = wbase + k;
            drive(1'b1, 1'b1, we, w << 2, d, 4'hF, (eob && k == n - 1) ? 3'b111 : ctype, bte);
            if (!we && k != err_beat) exp_q.push_back(model[w]);
            if (k == 0) begin
                wait_term(lat, a, e);
                chk({tag, "_lat"}, lat, first_lat(ws));
            end else begin
                @(negedge clk);
                a = bus.wb_ack_o;
                e = bus.wb_err_o;
            end
            if (k == err_beat) begin
                chk($sformatf("%s_err%0d", tag, k), {30'd0, a, e}, 32'd1);
                errored = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            chk($sformatf("%s_ack%0d", tag, k), {30'd0, a, e}, 32'd2);
            if (a) begin
                if (we) model[w] = d;
                else sb_pop($sformatf("%s_data%0d", tag, k));
            end else if (!we) begin
                void'(exp_q.pop_back());
            end
            if (ctype == 3'b010) w = (w & ~mask) | ((w + 1) & mask);
            @(posedge clk);
            #1;
        end
        if (errored) begin
            bus_idle(2);
        end else if (eob) begin
            drive(1'b1, 1'b1, 1'b0, adr0, 32'h0, 4'hF, 3'b000, 2'b00);
            @(negedge clk);
            chk({tag, "_eob_ack_low"}, {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
            @(posedge clk);
            #1;
            bus_idle(2);
        end else begin
            drive(1'b1, 1'b0, we, w << 2, 32'h0, 4'hF, ctype, bte);
            for (int unsigned g = 0; g < 2; g++) begin
                @(negedge clk);
                chk($sformatf("%s_gap%0d_ack_low", tag, g), {31'd0, bus.wb_ack_o}, 32'd0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [31:0] lat;
        logic        a, e;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
        @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("rst_err", {31'd0, bus.wb_err_o}, 32'd0);
        chk("rst_rty", {31'd0, bus.wb_rty_o}, 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back classic write then read; byte-lane merge
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr10");
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "rd10");
        classic(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, "wrb10");
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "rdb10");
        bus_idle(2);

        for (int unsigned i = 0; i < 4; i++)
            classic(1'b1, 32'h30 + 4 * i, i, 4'hF, 1'b0, $sformatf("wr3x_%0d", i));
        bus_idle(2);
        burst(1'b0, 32'h38, 4, 2'b01, 3'b010, 32'h0, NONE, 1'b1, "wrap4");

        // linear write with a 2-cycle strobe gap after beat 3, then read-back
        burst(1'b1, 32'h00, 4, 2'b00, 3'b010, 32'd0, NONE, 1'b0, "lin_a");
        burst(1'b1, 32'h10, 4, 2'b00, 3'b010, 32'd4, NONE, 1'b1, "lin_b");
        burst(1'b0, 32'h00, 8, 2'b00, 3'b010, 32'h0, NONE, 1'b1, "lin_rd");

        burst(1'b0, 32'h18, 4, 2'b10, 3'b010, 32'h0, NONE, 1'b1, "wrap8");
        burst(1'b0, 32'h10, 3, 2'b01, 3'b001, 32'h0, NONE, 1'b1, "const");

        // out of range: err each strobe, memory untouched
        classic(1'b1, 32'h400, 32'hBAD0BAD0, 4'hF, 1'b1, "oor0");
        classic(1'b1, 32'h400, 32'hBAD0BAD0, 4'hF, 1'b1, "oor1");
        bus_idle(2);
        classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, "oor_w0");
        bus_idle(2);

        classic(1'b1, 32'h3FC, 32'h12345678, 4'hF, 1'b0, "wr255");
        bus_idle(2);
        burst(1'b0, 32'h3FC, 2, 2'b00, 3'b010, 32'h0, 32'd1, 1'b1, "edge255");

        ws = 4'd3;
        burst(1'b0, 32'h00, 4, 2'b00, 3'b010, 32'h0, NONE, 1'b1, "wait3");
        ws = 4'd0;

        // asynchronous reset in the middle of a burst
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b00);
        wait_term(lat, a, e);
        chk("rstmid_first_ack", {31'd0, a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("rstmid_err", {31'd0, bus.wb_err_o}, 32'd0);
        chk("rstmid_dat", bus.wb_dat_o, 32'd0);
        @(posedge clk);
        #1;
        bus_idle(1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "post_rst");
        bus_idle(2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
